uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Double-buffered UART transmitter: 8 data bits LSB first, one start bit, one stop bit, optional parity. A one-byte holding register sits in front of the shift register, so the host can queue the next byte while the current frame shifts out. Consecutive frames leave the line with no idle gap. The block is the transmit half of each DUART channel and talks directly to the host-side register interface.

## Interface
- CLKS_PER_BIT, default 32: i_Clock cycles per bit, calculated as (clock frequency)/(baud rate). Must be at least 2.
- i_Clock  in  1  system clock; all logic runs on its rising edge.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_TX_DV  in  1  write strobe, one cycle wide; offers i_TX_Byte to the holding register.
- i_TX_Byte  in  8  byte to transmit; sampled only while i_TX_DV=1.
- i_TX_En  in  1  transmitter enable; gates loading of new frames.
- i_Parity_Odd  in  1  0 selects even parity, 1 selects odd. Port exists only when UART_TX_PARITY_EN is defined.
- o_TX_Serial  out  1  serial line. Registered; idles high.
- o_TX_RDY  out  1  holding register empty, a write will be accepted.
- o_TX_EMT  out  1  holding register empty and shifter idle.
- o_TX_Done  out  1  one-cycle pulse when a stop bit completes.

## Operation
- Reset values: o_TX_Serial=1, o_TX_RDY=1, o_TX_EMT=0→1 (reset value 1), o_TX_Done=0, state IDLE, holding register empty.
- Write rules:
  - i_TX_DV with o_TX_RDY=1: the byte is captured into the holding register and o_TX_RDY goes to 0 on the next edge.
  - i_TX_DV with o_TX_RDY=0: the write is ignored and the holding register is unchanged.
- States: IDLE, START, DATA, PARITY (parity builds only), STOP.
- IDLE: the line is 1. If the holding register is full and i_TX_En=1, the next edge does the following:
  - moves the byte into the shifter;
  - sets o_TX_RDY=1;
  - drives o_TX_Serial=0;
  - enters START.
- START, DATA, PARITY and STOP each last exactly CLKS_PER_BIT cycles.
  - A counter of width $clog2(CLKS_PER_BIT) runs from 0 to CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - DATA outputs shifter bits 0 through 7 in order, using a 3-bit index.
- STOP: the line is 1. On the last STOP cycle, the next edge:
  - pulses o_TX_Done;
  - goes back-to-back to START if the holding register is full and i_TX_En=1, loading the shifter as in IDLE;
  - otherwise goes to IDLE.
- Simultaneous write and transfer: if the host writes on the same edge that the holding register empties into the shifter, the new byte is accepted and o_TX_RDY stays 0.
- i_TX_En=0 never aborts a frame in progress. It only stops the next load; queued data is held until the enable returns.
- o_TX_EMT=1 exactly when the state is IDLE and the holding register is empty.
- Asserting reset mid-frame aborts the frame immediately. The line goes to 1 and the queued byte is discarded.

## Timing
- Write accepted at edge N, transmitter idle and enabled:
  - holding register is full after edge N;
  - start bit begins at edge N+1;
  - o_TX_RDY=0 only during cycle N to N+1.
- Frame length is 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- o_TX_Done is high for the single cycle that starts at the edge ending the stop bit.
- Back-to-back frames: the next start bit begins on the same edge as o_TX_Done, with zero idle cycles between frames.

## Configuration
- UART_TX_PARITY_EN defined:
  - adds the i_Parity_Odd port and the PARITY state between DATA and STOP;
  - parity bit = XOR of the 8 data bits, XOR i_Parity_Odd;
  - i_Parity_Odd is sampled when the shifter is loaded.
- UART_TX_PARITY_EN undefined: no port, no PARITY state, DATA goes straight to STOP, fixed 8N1 framing.

## Test plan
- Reset, then write 0xA5 with CLKS_PER_BIT=32 and enable high. The line must hold each bit for 32 cycles in the order 0,1,0,1,0,0,1,0,1,1. o_TX_Done pulses 320 cycles after the start edge, and o_TX_EMT returns to 1 on that edge.
- Write 0x55, then write 0x0F during its DATA phase. o_TX_RDY stays low until the 0x55 stop bit ends. The 0x0F start bit follows with no gap, and two o_TX_Done pulses occur 320 cycles apart.
- With a byte shifting and a second byte queued, write 0xFF. The write is ignored, and only the first two bytes appear on the line.
- Hold i_TX_En=0 and write 0x3C. The line stays 1, o_TX_RDY=0 and o_TX_EMT=0. Raise i_TX_En: the start bit follows one edge later.
- Assert i_Rst_L=0 during bit 4 of a frame. o_TX_Serial=1, o_TX_RDY=1 and o_TX_EMT=1 immediately, with no o_TX_Done pulse.
- Parity build, transmit 0xA5 (four ones). The parity bit is 0 with i_Parity_Odd=0 and 1 with i_Parity_Odd=1. The frame is 352 cycles long.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Double-buffered 8-bit UART transmitter: a holding register in front of the shifter, back-to-back frames.
// Define UART_TX_PARITY_EN to add an even/odd parity bit (and the i_Parity_Odd port) between data and stop.
`timescale 1ns/1ps

module uart_tx_buffered #(
    parameter int CLKS_PER_BIT = 32
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_En,
`ifdef UART_TX_PARITY_EN
    input  logic       i_Parity_Odd,
`endif
    output logic       o_TX_Serial,
    output logic       o_TX_RDY,
    output logic       o_TX_EMT,
    output logic       o_TX_Done
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shifter;
    logic [7:0]    hold;
    logic          hold_full;
`ifdef UART_TX_PARITY_EN
    logic          par_bit;
`endif

    logic bit_end;
    logic load;
    logic accept;

    assign bit_end = (cnt == LAST);
    // The shifter takes the queued byte from IDLE, or straight out of the last stop cycle for zero-gap frames.
    assign load    = hold_full && i_TX_En && ((state == IDLE) || ((state == STOP) && bit_end));
    // A write landing on the transfer edge refills the holding register even though it currently reads full.
    assign accept  = i_TX_DV && (!hold_full || load);

    assign o_TX_RDY = !hold_full;
    assign o_TX_EMT = (state == IDLE) && !hold_full;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shifter     <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            o_TX_Serial <= 1'b1;
            o_TX_Done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit     <= 1'b0;
`endif
        end else begin
            o_TX_Done <= 1'b0;

            if (load)
                hold_full <= 1'b0;
            if (accept) begin
                hold      <= i_TX_Byte;
                hold_full <= 1'b1;
            end

            if (state == IDLE)
                cnt <= '0;
            else
                cnt <= bit_end ? '0 : cnt + 1'b1;

            case (state)
                IDLE: o_TX_Serial <= 1'b1;
                START: begin
                    if (bit_end) begin
                        state       <= DATA;
                        bit_idx     <= 3'd0;
                        o_TX_Serial <= shifter[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state       <= PARITY;
                            o_TX_Serial <= par_bit;
`else
                            state       <= STOP;
                            o_TX_Serial <= 1'b1;
`endif
                        end else begin
                            bit_idx     <= bit_idx + 3'd1;
                            o_TX_Serial <= shifter[bit_idx + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state       <= STOP;
                        o_TX_Serial <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        o_TX_Done   <= 1'b1;
                        state       <= IDLE;
                        o_TX_Serial <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    o_TX_Serial <= 1'b1;
                end
            endcase

            // Loading overrides the IDLE/STOP next-state choices above.
            if (load) begin
                shifter     <= hold;
                state       <= START;
                o_TX_Serial <= 1'b0;
`ifdef UART_TX_PARITY_EN
                par_bit     <= (^hold) ^ i_Parity_Odd;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Randomized bench for uart_tx_buffered; every cycle is checked against a frame-schedule model
// (which byte starts at which edge) rather than a state machine.
`timescale 1ns/1ps

module tb_uart_tx_buffered;

    localparam int C = 32;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       en = 1'b0;
    logic       par_odd = 1'b0;
    logic       serial, rdy, emt, done;

    always #5 clk = ~clk;

    uart_tx_buffered #(.CLKS_PER_BIT(C)) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_n),
        .i_TX_DV     (dv),
        .i_TX_Byte   (byte_in),
        .i_TX_En     (en),
`ifdef UART_TX_PARITY_EN
        .i_Parity_Odd(par_odd),
`endif
        .o_TX_Serial (serial),
        .o_TX_RDY    (rdy),
        .o_TX_EMT    (emt),
        .o_TX_Done   (done)
    );

    typedef struct {
        int         st;
        logic [7:0] b;
        logic       p;
    } frame_t;

    frame_t     frames[$];
    int         t = 0;
    int         last_end = 0;
    int         n_chk = 0;
    int         n_err = 0;
    logic       pend = 1'b0;
    logic [7:0] m_hold = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    // Line level after edge tt: start 0, data LSB first, optional parity, stop 1, idle 1.
    function automatic logic exp_line(input int tt);
        int k;
        foreach (frames[i]) begin
            if (tt >= frames[i].st && tt < frames[i].st + FRAME) begin
                k = (tt - frames[i].st) / C;
                if (k == 0) return 1'b0;
                if (k <= 8) return frames[i].b[k-1];
                if (k == 9 && NB == 11) return frames[i].p;
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_done(input int tt);
        foreach (frames[i])
            if (frames[i].st + FRAME == tt) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cyc(input logic d, input logic [7:0] b, input logic e);
        logic ld, acc;
        dv = d;
        byte_in = b;
        en = e;
        @(posedge clk);
        t++;
        ld  = pend && e && (t >= last_end);
        acc = d && (!pend || ld);
        if (ld) begin
            frames.push_back('{st: t, b: m_hold, p: (^m_hold) ^ par_odd});
            last_end = t + FRAME;
            pend = 1'b0;
        end
        if (acc) begin
            pend = 1'b1;
            m_hold = b;
        end
        #1;
        chk("serial", {31'd0, serial}, {31'd0, exp_line(t)});
        chk("done",   {31'd0, done},   {31'd0, exp_done(t)});
        chk("rdy",    {31'd0, rdy},    {31'd0, !pend});
        chk("emt",    {31'd0, emt},    {31'd0, (!pend && t >= last_end)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1);
    endtask

    // Called between edges: reset acts asynchronously and the model forgets everything queued.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_serial", {31'd0, serial}, 32'd1);
        chk("rst_rdy",    {31'd0, rdy},    32'd1);
        chk("rst_emt",    {31'd0, emt},    32'd1);
        chk("rst_done",   {31'd0, done},   32'd0);
        frames.delete();
        pend = 1'b0;
        last_end = 0;
        dv = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        #12;
        do_reset();

        cyc(1'b1, 8'hA5, 1'b1);
        idle(340);

        cyc(1'b1, 8'h55, 1'b1);
        idle(100);
        cyc(1'b1, 8'h0F, 1'b1);
        idle(700);

        cyc(1'b1, 8'h11, 1'b1);
        idle(5);
        cyc(1'b1, 8'h22, 1'b1);
        idle(50);
        cyc(1'b1, 8'hFF, 1'b1);
        idle(700);

        // Write exactly on the edge where the queued byte moves into the shifter.
        cyc(1'b1, 8'h81, 1'b1);
        idle(3);
        cyc(1'b1, 8'h42, 1'b1);
        guard = 0;
        while (t + 1 < last_end && guard < 2000) begin
            cyc(1'b0, 8'h00, 1'b1);
            guard++;
        end
        chk("xfer_align", t + 1, last_end);
        cyc(1'b1, 8'h99, 1'b1);
        idle(1000);

        cyc(1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b0);
        idle(340);

        cyc(1'b1, 8'hC3, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h5A, 1'b1);
        idle(5 * C + 10);
        do_reset();
        idle(40);

        par_odd = 1'b0;
        cyc(1'b1, 8'hA5, 1'b1);
        idle(360);
        par_odd = 1'b1;
        cyc(1'b1, 8'hA5, 1'b1);
        idle(360);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) par_odd = ~par_odd;
            cyc($urandom_range(0, 39) == 0, 8'($urandom), $urandom_range(0, 15) != 0);
        end
        idle(800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
